arcade_input: RTL
=================

# arcade_input

Parametrised player-input front end between `hps_io` and the game core. Decodes PS/2 key events into held-key state, merges them with MiSTer joystick words, and stretches coin presses into fixed-width pulses. It drives registered, per-player packed direction, button, start and coin vectors. It generalises the fixed two-player, three-button keyboard/joystick merge to `PLAYERS` players and `BUTTONS` buttons, and adds coin stretching and optional autofire.

## Interface
Parameters:
- `PLAYERS`, 2: number of players, 1–4.
- `BUTTONS`, 3: buttons per player, 1–6.
- `CLK_FREQ`, 96.0: `clk` frequency in MHz (real).
- `COIN_PULSE_MS`, 100: coin output pulse width in ms.
- `AUTOFIRE_HZ`, 15: autofire toggle rate in Hz.

Ports (JW = BUTTONS+6):
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_key`  in  11  [10] toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
- `joystick`  in  PLAYERS*JW  per player p, slice [p*JW +: JW]: [0] right, [1] left, [2] down, [3] up, [4 +: BUTTONS] buttons, [4+BUTTONS] start, [5+BUTTONS] coin.
- `autofire_mask`  in  BUTTONS  per-button autofire enable, shared by all players.
- `dir`  out  PLAYERS*4  per player {up, down, right, left}.
- `btn`  out  PLAYERS*BUTTONS  per-player buttons, bit 0 = button 1.
- `start`  out  PLAYERS  start, bit p = player p+1.
- `coin`  out  PLAYERS  stretched coin pulse.

## Operation
- Key decode: an internal toggle register tracks `ps2_key[10]`. When they differ, at the next edge the toggle register updates and the matching key register loads `ps2_key[9]`. Unmatched codes are ignored.
- Keymap, player 1: up 75, down 72, left 6B, right 74, btn1 14, btn2 11, btn3 29, start 16, coin 2E.
- Keymap, player 2: up 2D, down 2B, left 23, right 34, btn1 1C, btn2 1B, btn3 15, start 1E, coin 36.
- Buttons 4–6 and players 3–4 have no keys; they are joystick-only.
- Merge: each raw signal is the OR of its key register and the matching joystick bit. Keys for players ≥ `PLAYERS` are decoded but discarded.
- Coin: one FSM per player with states IDLE, PULSE and WAIT_REL.
  - IDLE → PULSE on a raw-coin rising edge; the counter loads COIN_CYCLES−1 = round(CLK_FREQ·1000·COIN_PULSE_MS)−1.
  - PULSE: `coin`=1. The counter decrements each cycle. At 0 go to WAIT_REL if raw coin is high, otherwise IDLE.
  - WAIT_REL → IDLE when raw coin is low.
  - Raw edges during PULSE or WAIT_REL are ignored.
- Counter width is `$clog2(COIN_CYCLES)`; never wraps.
- Reset clears all key registers, the toggle register (loaded from 0; first differing toggle is treated as an event), coin FSMs (IDLE), counters, and all outputs to 0.
- Reset mid-pulse terminates the pulse immediately.

## Timing
- `ps2_key` toggle change sampled at edge N: key register updates at N, output reflects it at N+1.
- `joystick` change: output updates at the next edge (1 cycle).
- Coin: raw rising edge at edge N; `coin` is high from N+1 for exactly COIN_CYCLES cycles.
- Simultaneous key release and joystick press on the same signal: output stays 1 (OR).
- Two `ps2_key` events on consecutive cycles: both are processed, one per cycle.

## Configuration
- `ARCADE_INPUT_AUTOFIRE_EN` defined:
  - A shared half-period counter of round(CLK_FREQ·1e6/(2·AUTOFIRE_HZ)) cycles drives a phase bit.
  - For button b with `autofire_mask[b]`=1, output = raw AND phase.
  - The phase resets to 1 and its counter restarts on any masked button's raw rising edge, so the first shot lands one cycle after the press.
- Undefined: `autofire_mask` is ignored, `btn` equals raw buttons, and no autofire counter is synthesised.

## Test plan
Use CLK_FREQ=0.01, so COIN_CYCLES=1000 at 100 ms.
- Reset check: assert `reset` with a joystick button held → all outputs 0. Release reset → `btn` goes to 1 one cycle later.
- Key event: toggle `ps2_key` = {1,1,0,8'h75} → `dir[3]`=1 two edges later. Toggle with {0,1,0,8'h75} → `dir[3]`=0.
- Extended and unmapped codes: `ps2_key` code 8'h74 with [8]=1 → player-1 right. Code 8'h5A → no output change.
- Coin stretch: raw coin high for 5 cycles → `coin[0]` high for exactly 1000 cycles. Coin held 2000 cycles → a single 1000-cycle pulse, with no retrigger until release.
- Merge and mid-pulse reset: key 2D held plus `joystick[JW+3]`; release the key → `dir[7]` stays 1. Reset at cycle 500 of a coin pulse → `coin`=0 immediately.
- Autofire (AUTOFIRE_HZ=5, half-period 1000): `autofire_mask`=3'b001, button 1 held 5000 cycles → output high 1000 cycles, low 1000 cycles, repeating from the cycle after the press. Without the macro → output constant 1.

Source files
------------

// File: rtl/arcade_input.sv
// -----------------------------------------------------------------------------
// arcade_input
//
// Player-input front end between hps_io and the game core. PS/2 key events
// are decoded into held-key registers, ORed with the MiSTer joystick words,
// and presented as registered per-player direction, button, start and coin
// vectors. Coin presses are stretched into fixed-width pulses.
//
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN
//   defined   -> buttons selected by autofire_mask are gated by a shared
//                square wave at AUTOFIRE_HZ
//   undefined -> autofire_mask is ignored and btn is the raw button state
//
// Parameters
//   PLAYERS        number of players (1..4)
//   BUTTONS        buttons per player (1..6)
//   CLK_FREQ       clk frequency in MHz
//   COIN_PULSE_MS  coin output pulse width in ms
//   AUTOFIRE_HZ    autofire toggle rate in Hz
//
// Ports (JW = BUTTONS+6)
//   clk            system clock
//   reset          asynchronous active-high reset
//   ps2_key        [10] toggle, [9] pressed, [8] extended (ignored), [7:0] code
//   joystick       per player p at [p*JW +: JW]: [0] right, [1] left,
//                  [2] down, [3] up, [4 +: BUTTONS] buttons,
//                  [4+BUTTONS] start, [5+BUTTONS] coin
//   autofire_mask  per-button autofire enable, shared by all players
//   dir            per player {up, down, right, left}
//   btn            per player buttons, bit 0 = button 1
//   start          start, bit p = player p+1
//   coin           stretched coin pulse per player
// -----------------------------------------------------------------------------
module arcade_input #(
    parameter int  PLAYERS       = 2,
    parameter int  BUTTONS       = 3,
    parameter real CLK_FREQ      = 96.0,
    parameter int  COIN_PULSE_MS = 100,
    parameter int  AUTOFIRE_HZ   = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [10:0]                     ps2_key,
    input  logic [PLAYERS*(BUTTONS+6)-1:0]  joystick,
    input  logic [BUTTONS-1:0]              autofire_mask,
    output logic [PLAYERS*4-1:0]            dir,
    output logic [PLAYERS*BUTTONS-1:0]      btn,
    output logic [PLAYERS-1:0]              start,
    output logic [PLAYERS-1:0]              coin
);

    localparam int JW          = BUTTONS + 6;
    localparam int COIN_CYCLES = $rtoi(CLK_FREQ * 1000.0 * COIN_PULSE_MS + 0.5);
    localparam int CW          = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;

    // Key register layout, 9 per keyboard player:
    // [0] right [1] left [2] down [3] up [4..6] btn1..3 [7] start [8] coin
    // (same low-bit order as the joystick word). Entry i sits at [i*8 +: 8].
    localparam int NKEYS = 18;
    localparam logic [NKEYS*8-1:0] KEY_CODES = {
        8'h36, 8'h1E, 8'h15, 8'h1B, 8'h1C, 8'h2D, 8'h2B, 8'h23, 8'h34,  // player 2
        8'h2E, 8'h16, 8'h29, 8'h11, 8'h14, 8'h75, 8'h72, 8'h6B, 8'h74   // player 1
    };

    // -------------------------------------------------------------------------
    // PS/2 key decode
    // -------------------------------------------------------------------------
    logic             toggle_q, toggle_d;
    logic [NKEYS-1:0] key_q, key_d;
    logic             key_event;

    // hps_io flips bit 10 once per key event; a mismatch with the last seen
    // value means a new event is waiting.
    assign key_event = ps2_key[10] ^ toggle_q;

    always_comb begin
        toggle_d = ps2_key[10];
        key_d    = key_q;
        if (key_event) begin
            for (int i = 0; i < NKEYS; i++) begin
                if (ps2_key[7:0] == KEY_CODES[i*8 +: 8]) begin
                    key_d[i] = ps2_key[9];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Keyboard / joystick merge
    // -------------------------------------------------------------------------
    logic [PLAYERS*4-1:0]       raw_rldu;   // per player {up, down, left, right}
    logic [PLAYERS*BUTTONS-1:0] raw_btn;
    logic [PLAYERS-1:0]         raw_start;
    logic [PLAYERS-1:0]         raw_coin;

    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_merge
        logic [8:0] keys;

        // Only players 1 and 2 have keyboard mappings.
        if (gi < 2) begin : g_keys
            assign keys = key_q[gi*9 +: 9];
        end else begin : g_nokeys
            assign keys = '0;
        end

        assign raw_rldu[gi*4 +: 4] = keys[3:0] | joystick[gi*JW +: 4];
        assign raw_start[gi]       = keys[7] | joystick[gi*JW + 4 + BUTTONS];
        assign raw_coin[gi]        = keys[8] | joystick[gi*JW + 5 + BUTTONS];

        for (genvar bi = 0; bi < BUTTONS; bi++) begin : g_btn
            if (bi < 3) begin : g_keyed
                assign raw_btn[gi*BUTTONS + bi] = keys[4 + bi] | joystick[gi*JW + 4 + bi];
            end else begin : g_joy_only
                assign raw_btn[gi*BUTTONS + bi] = joystick[gi*JW + 4 + bi];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    logic [PLAYERS*4-1:0]       dir_q, dir_d;
    logic [PLAYERS*BUTTONS-1:0] btn_q, btn_d;
    logic [PLAYERS-1:0]         start_q, start_d;

    always_comb begin
        dir_d   = '0;
        start_d = raw_start;
        for (int p = 0; p < PLAYERS; p++) begin
            // joystick order is {up, down, left, right}; output is {up, down, right, left}
            dir_d[p*4 +: 4] = {raw_rldu[p*4 + 3], raw_rldu[p*4 + 2],
                               raw_rldu[p*4 + 0], raw_rldu[p*4 + 1]};
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    // -------------------------------------------------------------------------
    // Autofire: shared square wave, re-phased on every masked button press so
    // the first shot is never swallowed by an unlucky phase.
    // -------------------------------------------------------------------------
    localparam int HALF = $rtoi(CLK_FREQ * 1.0e6 / (2.0 * AUTOFIRE_HZ) + 0.5);
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [AW-1:0]              af_cnt_q, af_cnt_d;
    logic                       af_phase_q, af_phase_d;
    logic [PLAYERS*BUTTONS-1:0] btn_prev_q, btn_prev_d;
    logic                       af_restart;

    always_comb begin
        btn_prev_d = raw_btn;
        af_restart = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int b = 0; b < BUTTONS; b++) begin
                if (autofire_mask[b] && raw_btn[p*BUTTONS + b] && !btn_prev_q[p*BUTTONS + b]) begin
                    af_restart = 1'b1;
                end
            end
        end

        af_phase_d = af_phase_q;
        af_cnt_d   = af_cnt_q;
        if (af_restart) begin
            af_phase_d = 1'b1;
            af_cnt_d   = AW'(HALF - 1);
        end else if (af_cnt_q == '0) begin
            af_phase_d = ~af_phase_q;
            af_cnt_d   = AW'(HALF - 1);
        end else begin
            af_cnt_d   = af_cnt_q - AW'(1);
        end

        // Use the next phase so a press that restarts the wave fires at once.
        btn_d = raw_btn;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int b = 0; b < BUTTONS; b++) begin
                if (autofire_mask[b]) begin
                    btn_d[p*BUTTONS + b] = raw_btn[p*BUTTONS + b] & af_phase_d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
            btn_prev_q <= '0;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ps2_key[8], key_q};
`else
    always_comb begin
        btn_d = raw_btn;
    end

    logic unused_bits;
    assign unused_bits = ^{ps2_key[8], key_q, autofire_mask};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_q <= 1'b0;
            key_q    <= '0;
            dir_q    <= '0;
            btn_q    <= '0;
            start_q  <= '0;
        end else begin
            toggle_q <= toggle_d;
            key_q    <= key_d;
            dir_q    <= dir_d;
            btn_q    <= btn_d;
            start_q  <= start_d;
        end
    end

    assign dir   = dir_q;
    assign btn   = btn_q;
    assign start = start_q;

    // -------------------------------------------------------------------------
    // Coin stretchers, one FSM per player
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_REL = 2'd2
    } coin_state_t;

    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_coin
        coin_state_t   state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          prev_q, prev_d;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                prev_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                prev_q  <= prev_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            prev_d  = raw_coin[gi];
            case (state_q)
                IDLE: begin
                    if (raw_coin[gi] && !prev_q) begin
                        state_d = PULSE;
                        cnt_d   = CW'(COIN_CYCLES - 1);
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        // A coin still held must be released before it counts again.
                        state_d = raw_coin[gi] ? WAIT_REL : IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                WAIT_REL: begin
                    if (!raw_coin[gi]) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        assign coin[gi] = (state_q == PULSE);
    end

endmodule
